// File: rtl/iss_window.sv
// Issue window: holds decoded ops until both operands are ready, then issues the
// oldest eligible op per port (age measured from the ROB head). Results broadcast on
// the wakeup ports make waiting operands ready, and a flush kills speculative entries.
module iss_window #(
    parameter int unsigned           DEPTH         = 8,
    parameter int unsigned           UNITS         = 3,
    parameter int unsigned           WB_PORTS      = 2,
    parameter int unsigned           ROB_DEPTHLOG2 = 4,
    parameter int unsigned           PW            = 64,
    parameter logic [UNITS-1:0][1:0] UNIT_CLASS    = {2'd2, 2'd1, 2'd0}
) (
    input  logic                                    clock,
    input  logic                                    reset,
    // enqueue
    input  logic                                    enq_valid,
    output logic                                    enq_ready,
    input  logic [PW-1:0]                           enq_payload,
    input  logic [1:0]                              enq_class,
    input  logic [ROB_DEPTHLOG2-1:0]                enq_rob_slot,
    input  logic                                    enq_spec,
    input  logic                                    enq_A_ready,
    input  logic [ROB_DEPTHLOG2-1:0]                enq_A_tag,
    input  logic [31:0]                             enq_A_val,
    input  logic                                    enq_B_ready,
    input  logic [ROB_DEPTHLOG2-1:0]                enq_B_tag,
    input  logic [31:0]                             enq_B_val,
    // wakeup
    input  logic [WB_PORTS-1:0]                     wb_valid,
    input  logic [WB_PORTS-1:0][ROB_DEPTHLOG2-1:0]  wb_rob_slot,
    input  logic [WB_PORTS-1:0][31:0]               wb_val,
    // control
    input  logic [ROB_DEPTHLOG2-1:0]                rob_head,
    input  logic                                    flush,
    input  logic                                    spec_clear,
    // issue
    output logic [UNITS-1:0]                        iss_valid,
    input  logic [UNITS-1:0]                        iss_ready,
    output logic [UNITS-1:0][PW-1:0]                iss_payload,
    output logic [UNITS-1:0][31:0]                  iss_A,
    output logic [UNITS-1:0][31:0]                  iss_B,
    output logic [UNITS-1:0][ROB_DEPTHLOG2-1:0]     iss_rob_slot,
    output logic [$clog2(DEPTH):0]                  occupancy
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned OW = IW + 1;
    localparam int unsigned RW = ROB_DEPTHLOG2;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] spec_q, spec_d;
    logic [DEPTH-1:0] a_rdy_q, a_rdy_d;
    logic [DEPTH-1:0] b_rdy_q, b_rdy_d;
    logic [1:0]       cls_q   [DEPTH];
    logic [1:0]       cls_d   [DEPTH];
    logic [RW-1:0]    rob_q   [DEPTH];
    logic [RW-1:0]    rob_d   [DEPTH];
    logic [PW-1:0]    pay_q   [DEPTH];
    logic [PW-1:0]    pay_d   [DEPTH];
    logic [RW-1:0]    a_tag_q [DEPTH];
    logic [RW-1:0]    a_tag_d [DEPTH];
    logic [31:0]      a_val_q [DEPTH];
    logic [31:0]      a_val_d [DEPTH];
    logic [RW-1:0]    b_tag_q [DEPTH];
    logic [RW-1:0]    b_tag_d [DEPTH];
    logic [31:0]      b_val_q [DEPTH];
    logic [31:0]      b_val_d [DEPTH];

    logic [IW-1:0]            free_idx;
    logic [UNITS-1:0][IW-1:0] sel_idx;

    // Snoop the wakeup bus for one operand; the lowest-numbered matching port wins.
    function automatic logic [32:0] snoop(
        input logic                         rdy,
        input logic [RW-1:0]                tag,
        input logic [31:0]                  val,
        input logic [WB_PORTS-1:0]          v,
        input logic [WB_PORTS-1:0][RW-1:0]  s,
        input logic [WB_PORTS-1:0][31:0]    d
    );
        logic [32:0] r;
        logic        hit;
        r   = {rdy, val};
        hit = rdy;
        for (int p = 0; p < int'(WB_PORTS); p++) begin
            if (!hit && v[p] && (s[p] == tag)) begin
                hit = 1'b1;
                r   = {1'b1, d[p]};
            end
        end
        return r;
    endfunction

    // Occupancy is the population count of valid entries.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occupancy = occupancy + OW'(valid_q[i]);
        end
    end

    assign enq_ready = (occupancy < OW'(DEPTH));

    // Lowest-index free entry; entries freed by issue this cycle are not yet free.
    always_comb begin
        free_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IW'(i);
        end
    end

    // Per-port oldest-first selection, ports in ascending order; independent of iss_ready.
    always_comb begin
        logic [DEPTH-1:0] granted;
        logic             found;
        logic [RW-1:0]    age;
        logic [RW-1:0]    best_age;
        logic [IW-1:0]    best;
        granted      = '0;
        iss_valid    = '0;
        iss_payload  = '0;
        iss_A        = '0;
        iss_B        = '0;
        iss_rob_slot = '0;
        sel_idx      = '0;
        for (int u = 0; u < int'(UNITS); u++) begin
            found    = 1'b0;
            best_age = '0;
            best     = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                age = rob_q[i] - rob_head;
                if (valid_q[i] && a_rdy_q[i] && b_rdy_q[i] && !granted[i] &&
                    (cls_q[i] == UNIT_CLASS[u]) && (!found || (age < best_age))) begin
                    found    = 1'b1;
                    best_age = age;
                    best     = IW'(i);
                end
            end
            sel_idx[u] = best;
            if (found) granted[best] = 1'b1;
            // A flush masks speculative grants without releasing them to other entries.
            iss_valid[u] = found && !(flush && spec_q[best]);
            if (iss_valid[u]) begin
                iss_payload[u]  = pay_q[best];
                iss_A[u]        = a_val_q[best];
                iss_B[u]        = b_val_q[best];
                iss_rob_slot[u] = rob_q[best];
            end
        end
    end

    // Next entry state: wakeup, issue transfers, flush/spec_clear, then enqueue.
    always_comb begin
        valid_d = valid_q;
        spec_d  = spec_q;
        a_rdy_d = a_rdy_q;
        b_rdy_d = b_rdy_q;
        cls_d   = cls_q;
        rob_d   = rob_q;
        pay_d   = pay_q;
        a_tag_d = a_tag_q;
        a_val_d = a_val_q;
        b_tag_d = b_tag_q;
        b_val_d = b_val_q;

        for (int i = 0; i < int'(DEPTH); i++) begin
            {a_rdy_d[i], a_val_d[i]} = snoop(a_rdy_q[i], a_tag_q[i], a_val_q[i],
                                             wb_valid, wb_rob_slot, wb_val);
            {b_rdy_d[i], b_val_d[i]} = snoop(b_rdy_q[i], b_tag_q[i], b_val_q[i],
                                             wb_valid, wb_rob_slot, wb_val);
        end

        for (int u = 0; u < int'(UNITS); u++) begin
            if (iss_valid[u] && iss_ready[u]) valid_d[sel_idx[u]] = 1'b0;
        end

        // Flush takes precedence over a coincident spec_clear.
        if (flush) begin
            valid_d = valid_d & ~spec_q;
        end else if (spec_clear) begin
            spec_d = '0;
        end

        if (enq_valid && enq_ready) begin
            valid_d[free_idx] = !(flush && enq_spec);
            spec_d[free_idx]  = enq_spec && !spec_clear && !flush;
            cls_d[free_idx]   = enq_class;
            rob_d[free_idx]   = enq_rob_slot;
            pay_d[free_idx]   = enq_payload;
            a_tag_d[free_idx] = enq_A_tag;
            b_tag_d[free_idx] = enq_B_tag;
            {a_rdy_d[free_idx], a_val_d[free_idx]} = snoop(enq_A_ready, enq_A_tag, enq_A_val,
                                                           wb_valid, wb_rob_slot, wb_val);
            {b_rdy_d[free_idx], b_val_d[free_idx]} = snoop(enq_B_ready, enq_B_tag, enq_B_val,
                                                           wb_valid, wb_rob_slot, wb_val);
        end
    end

    // Entry valid/spec bits; reset empties the window.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            spec_q  <= '0;
        end else begin
            valid_q <= valid_d;
            spec_q  <= spec_d;
        end
    end

    // Entry contents; only meaningful while the entry is valid.
    always_ff @(posedge clock) begin
        a_rdy_q <= a_rdy_d;
        b_rdy_q <= b_rdy_d;
        cls_q   <= cls_d;
        rob_q   <= rob_d;
        pay_q   <= pay_d;
        a_tag_q <= a_tag_d;
        a_val_q <= a_val_d;
        b_tag_q <= b_tag_d;
        b_val_q <= b_val_d;
    end

endmodule

// File: doc/iss_window.md
ISS_WINDOW -- requirements
Module: iss_window

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning window entries (power of 2, >=2).
REQ-002 The block SHALL have parameter UNITS, default 3, meaning issue ports.
REQ-003 The block SHALL have parameter WB_PORTS, default 2, meaning result-broadcast (wakeup) ports.
REQ-004 The block SHALL have parameter ROB_DEPTHLOG2, default 4, meaning ROB slot/tag width.
REQ-005 The block SHALL have parameter PW, default 64, meaning opaque decoded-instruction payload width.
REQ-006 The block SHALL have parameter UNIT_CLASS[UNITS], a 2-bit class per port (default {0,1,2}), meaning which instruction class each port accepts.
REQ-007 The block SHALL have one clock; reset is synchronous and active-high: ports clock (in, 1, rising-edge) and reset (in, 1, sync active-high).
REQ-008 Enqueue ports SHALL be: enq_valid in 1; enq_ready out 1; enq_payload in PW; enq_class in 2; enq_rob_slot in ROB_DEPTHLOG2; enq_spec in 1, speculative (after branch delay slot).
REQ-009 Operand ports SHALL be, for X in {A,B}: enq_X_ready in 1, value known; enq_X_tag in ROB_DEPTHLOG2, producing ROB slot; enq_X_val in 32.
REQ-010 Wakeup ports SHALL be: wb_valid[WB_PORTS] in 1; wb_rob_slot[WB_PORTS] in ROB_DEPTHLOG2; wb_val[WB_PORTS] in 32.
REQ-011 Control ports SHALL be: rob_head in ROB_DEPTHLOG2, oldest in-flight slot; flush in 1, kill speculative entries; spec_clear in 1, branch resolved, clear spec marks.
REQ-012 Issue ports SHALL be: iss_valid[UNITS] out 1; iss_ready[UNITS] in 1; iss_payload[UNITS] out PW; iss_A[UNITS] out 32; iss_B[UNITS] out 32; iss_rob_slot[UNITS] out ROB_DEPTHLOG2.
REQ-013 The block SHALL have occupancy out $clog2(DEPTH)+1, meaning count of valid entries.

Function
REQ-014 Each entry SHALL hold valid, spec, class, rob_slot, payload, and for A/B: ready, tag, 32-bit value.
REQ-015 enq_ready SHALL be 1 iff occupancy < DEPTH; on enq_valid&enq_ready the lowest-index free entry SHALL be written at the clock edge.
REQ-016 An entry freed by issue in cycle N SHALL NOT be reusable by an enqueue in cycle N (no same-cycle free/alloc bypass); full window deasserts enq_ready.
REQ-017 Wakeup: each valid wb port matching a not-ready operand tag SHALL set ready and capture wb_val at the edge; the lowest-numbered matching port wins.
REQ-018 Enqueue-cycle bypass: a not-ready enq operand whose tag matches a valid wb port in the same cycle SHALL be stored ready with wb_val.
REQ-019 An entry SHALL be eligible for issue when valid, both operands ready, and not already granted to a lower-numbered port this cycle; an entry written at edge N is first eligible in the cycle after N.
REQ-020 Port u SHALL select, among eligible entries with class == UNIT_CLASS[u], the oldest by age = (rob_slot - rob_head) mod 2^ROB_DEPTHLOG2; ties go to the lower index.
REQ-021 Port processing SHALL be in ascending u; one entry is granted to at most one port per cycle.
REQ-022 iss_valid[u] and iss_* data SHALL be combinational from entry state; a transfer occurs when iss_valid[u]&iss_ready[u], and the entry is invalidated at that edge.
REQ-023 Selection SHALL NOT depend on iss_ready (no combinational ready-to-valid path); an unaccepted grant persists and is re-evaluated next cycle.
REQ-024 When flush=1, iss_valid[u] SHALL be forced 0 for spec entries, and at the edge all spec entries SHALL be invalidated; an enqueue with enq_spec=1 in that cycle is accepted and discarded.
REQ-025 spec_clear=1 SHALL clear every entry's spec bit at the edge, including a same-cycle enqueue; if flush and spec_clear coincide, flush takes effect and spec_clear is ignored.
REQ-026 Occupancy SHALL update each edge as occupancy + enq_accepted - transfers - flushed, never exceeding DEPTH.

Reset
REQ-027 When reset is high at an edge, all entries SHALL be invalid, occupancy 0, enq_ready 1, iss_valid all 0, and iss_* data 0; reset overrides enqueue, wakeup, flush and issue in that cycle.

Verification
REQ-028 Enqueue class-0 op with A/B ready (A=5, B=7) into an empty window -> iss_valid[0]=1 the next cycle with iss_A=5, iss_B=7; the entry is freed after iss_ready[0]=1.
REQ-029 Enqueue with A not ready, tag 3; two cycles later wb_valid[1]=1, slot 3, val 0xDEAD -> issue the following cycle with iss_A=0xDEAD; same-cycle enq+wb gives issue next cycle.
REQ-030 rob_head=14, ready class-1 entries at slots 1 and 15 -> slot 15 issues first; wrap-around age is honoured.
REQ-031 Fill DEPTH entries with iss_ready all 0 -> enq_ready=0 and occupancy=DEPTH; one transfer -> enq_ready=1 the next cycle, not the same cycle.
REQ-032 Mix of 3 spec and 2 non-spec entries, flush=1 -> spec iss_valid is gated low that cycle and occupancy=2 next; flush+spec_clear together -> still occupancy=2.
REQ-033 Assert reset mid-operation with 5 entries pending -> the next cycle has occupancy=0, enq_ready=1, and all iss_valid=0.
